clause_checker_seq: RTL and testbench
=====================================

// Module: clause_checker_seq
// PURPOSE
//  Sequential, parametrised successor to the two-clause combinational checker. Evaluates NUM_CLAUSES
//  linear integer clauses a1*y1+...+aV*yV <= b against the current assignment.
//  Uses one time-multiplexed signed multiply-accumulate and a start/done handshake.
//  Sits between the clause store and the MCMC proposal logic; reports per-clause satisfaction.
// PARAMETERS
//  WIDTH        8  bit width of every coefficient, bound and variable (signed two's complement)
//  NUM_VARS     2  integer variables per clause (V)
//  NUM_CLAUSES  4  clauses evaluated per run (C)
//  EARLY_EXIT   0  1 = stop the run at the first violated clause
// PORTS
//  in_clk                 in   1          clock, rising edge
//  in_reset               in   1          asynchronous, active-low reset
//  in_enable              in   1          1 = advance; 0 = freeze all state (pause)
//  in_start               in   1          request a run; sampled only in IDLE with in_enable=1
//  in_coefficients        in   C*(V+1)*W  clause c at [c*(V+1)*W +: (V+1)*W]; inside it a_i at [i*W +: W], bound at i=V
//  in_current_assignment  in   V*W        y_i at [i*W +: W]
//  out_busy               out  1          1 in RUN
//  out_done               out  1          one-cycle pulse, results valid
//  out_clause_flags       out  C          bit c = 1 if clause c satisfied (sum <= bound)
//  out_all_satisfied      out  1          &out_clause_flags, valid with/after done
//  out_any_violated       out  1          1 if any evaluated clause failed
//  out_first_violated     out  clog2(C)   lowest violated clause index; 0 if none
// BEHAVIOUR
//  - Reset (in_reset=0): immediately IDLE, all outputs 0, counters/accumulator 0; a run in progress is aborted, no done.
//  - FSM IDLE->RUN on in_start & in_enable. Coefficients and assignment snapshot into registers on that edge.
//    Later input changes do not affect the run. Flags, all_satisfied, any_violated and first_violated clear on that edge.
//  - RUN: one product a_v*y_v per enabled cycle, v=0..V-1 per clause, c=0..C-1.
//    On v=V-1 the compare acc+prod <= sign-extended bound writes flag c, and acc clears.
//  - RUN->DONE after the last clause; DONE->IDLE on next enabled cycle.
//    out_done is high exactly in DONE (1 cycle), i.e. C*V+1 enabled cycles after the start edge.
//  - EARLY_EXIT=1: on first failed compare go to DONE next cycle; flags of unevaluated clauses stay 0.
//  - in_enable=0 in any state: hold everything, including out_done if in DONE; latency extends cycle-for-cycle.
//  - in_start while RUN/DONE is ignored (not queued).
//  - Arithmetic: products 2W bits signed; acc width 2W+clog2(V)+1 so no wrap for any inputs; bound sign-extended.
//  - first_violated updates only on the first failure in a run; results hold in IDLE until next start.
// STRUCTURE
//  - headers.v: WIDTH/NUM_VARS/NUM_CLAUSES defaults, FSM state encodings (IDLE=0, RUN=1, DONE=2), ACC_WIDTH macro.
//  - Sub-module clause_mac: signed W x W multiply plus ACC_WIDTH accumulate/clear.
//    Exposes the combinational next-sum for the compare. FSM, counters and flag register live in the top.
// TESTING (bench overrides NUM_CLAUSES=2, W=8, V=2; bound is the top byte)
//  1. clause0=24'h020101, clause1=24'h010101, y=16'h0101, start
//     -> done 5 cycles later; flags=2'b01, all_sat=0, any_viol=1, first_viol=1.
//  2. same coefficients, y=16'hffff (sums -2)
//     -> flags=2'b11, all_sat=1, any_viol=0, first_viol=0.
//  3. clause0=24'h7f8080, y=16'h8080 (sum +32768)
//     -> flag0=0, no wrap; clause0=24'h807f7f, y=16'h8080 (sum -32512) -> flag0=1.
//  4. in_enable low 3 cycles mid-RUN, then change inputs and pulse in_start during RUN
//     -> done 8 cycles after start, results match test 1, extra start ignored.
//  5. in_reset low mid-RUN
//     -> all outputs 0 same cycle, no done pulse; next start after release gives test 1 results.
//  6. EARLY_EXIT=1, clause0=24'h010101, y=16'h0101
//     -> done 3 cycles after start, flags=2'b00, first_viol=0, any_viol=1.

Source files
------------

// File: rtl/clause_checker_seq_pkg.sv
// Shared defaults, FSM state type and width helpers for the sequential clause checker.
package clause_checker_seq_pkg;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_NUM_VARS    = 2;
   localparam int DEF_NUM_CLAUSES = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Wide enough that a sum of V full-range products can never wrap.
   function automatic int acc_width(input int w, input int v);
      return 2 * w + $clog2(v) + 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clause_checker_seq_mac.sv
// Signed WIDTH x WIDTH multiply feeding an accumulator; sum_next is the
// combinational acc+product used by the clause compare.
module clause_checker_seq_mac #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 18
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    step,
   input  logic                    clr,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] y,
   output logic signed [ACC_W-1:0] sum_next
);

   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]   acc_q, acc_d;

   always_comb begin
      prod     = a * y;
      sum_next = acc_q + ACC_W'(prod);
      acc_d    = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (step) begin
         acc_d = sum_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/clause_checker_seq.sv
// Sequential linear-clause checker: one signed MAC per enabled cycle over a
// snapshot of the clause store, reporting per-clause satisfaction.
module clause_checker_seq
   import clause_checker_seq_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int NUM_VARS    = DEF_NUM_VARS,
   parameter int NUM_CLAUSES = DEF_NUM_CLAUSES,
   parameter int EARLY_EXIT  = 0
) (
   input  logic                                         in_clk,
   input  logic                                         in_reset,
   input  logic                                         in_enable,
   input  logic                                         in_start,
   input  logic [NUM_CLAUSES*(NUM_VARS+1)*WIDTH-1:0]    in_coefficients,
   input  logic [NUM_VARS*WIDTH-1:0]                    in_current_assignment,
   output logic                                         out_busy,
   output logic                                         out_done,
   output logic [NUM_CLAUSES-1:0]                       out_clause_flags,
   output logic                                         out_all_satisfied,
   output logic                                         out_any_violated,
   output logic [idx_width(NUM_CLAUSES)-1:0]            out_first_violated
);

   localparam int ACC_W = acc_width(WIDTH, NUM_VARS);
   localparam int VW    = idx_width(NUM_VARS);
   localparam int CW    = idx_width(NUM_CLAUSES);
   localparam int CLW   = (NUM_VARS + 1) * WIDTH;
   localparam logic [VW-1:0] V_LAST = VW'(NUM_VARS - 1);
   localparam logic [CW-1:0] C_LAST = CW'(NUM_CLAUSES - 1);

   state_e                          state_q, state_d;
   logic [NUM_CLAUSES*CLW-1:0]      coef_q, coef_d;
   logic [NUM_VARS*WIDTH-1:0]       asg_q, asg_d;
   logic [VW-1:0]                   v_q, v_d;
   logic [CW-1:0]                   c_q, c_d;
   logic                            fin_q, fin_d;
   logic [NUM_CLAUSES-1:0]          flags_q, flags_d;
   logic                            any_q, any_d;
   logic [CW-1:0]                   first_q, first_d;

   logic signed [WIDTH-1:0]         a_sel, y_sel, b_sel;
   logic signed [ACC_W-1:0]         sum_next, bound_ext;
   logic                            mac_step, mac_clr, sat;

   clause_checker_seq_mac #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk      (in_clk),
      .rst_n    (in_reset),
      .step     (mac_step),
      .clr      (mac_clr),
      .a        (a_sel),
      .y        (y_sel),
      .sum_next (sum_next)
   );

   always_comb begin
      a_sel = '0;
      y_sel = '0;
      b_sel = '0;
      for (int unsigned c = 0; c < NUM_CLAUSES; c++) begin
         if (c_q == CW'(c)) begin
            b_sel = coef_q[c*CLW + NUM_VARS*WIDTH +: WIDTH];
            for (int unsigned v = 0; v < NUM_VARS; v++) begin
               if (v_q == VW'(v)) a_sel = coef_q[c*CLW + v*WIDTH +: WIDTH];
            end
         end
      end
      for (int unsigned v = 0; v < NUM_VARS; v++) begin
         if (v_q == VW'(v)) y_sel = asg_q[v*WIDTH +: WIDTH];
      end
      bound_ext = ACC_W'(b_sel);
      sat       = (sum_next <= bound_ext);
   end

   // The final compare (or an early-exit failure) arms fin_q; DONE follows one enabled cycle later.
   always_comb begin
      state_d  = state_q;
      coef_d   = coef_q;
      asg_d    = asg_q;
      v_d      = v_q;
      c_d      = c_q;
      fin_d    = fin_q;
      flags_d  = flags_q;
      any_d    = any_q;
      first_d  = first_q;
      mac_step = 1'b0;
      mac_clr  = 1'b0;
      if (in_enable) begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_start) begin
                  state_d = ST_RUN;
                  coef_d  = in_coefficients;
                  asg_d   = in_current_assignment;
                  v_d     = '0;
                  c_d     = '0;
                  fin_d   = 1'b0;
                  flags_d = '0;
                  any_d   = 1'b0;
                  first_d = '0;
                  mac_clr = 1'b1;
               end
            end
            ST_RUN: begin
               if (fin_q) begin
                  state_d = ST_DONE;
                  fin_d   = 1'b0;
               end else begin
                  mac_step = 1'b1;
                  if (v_q == V_LAST) begin
                     mac_clr      = 1'b1;
                     v_d          = '0;
                     flags_d[c_q] = sat;
                     if (!sat) begin
                        any_d = 1'b1;
                        if (!any_q) first_d = c_q;
                     end
                     if ((c_q == C_LAST) || ((EARLY_EXIT != 0) && !sat)) begin
                        fin_d = 1'b1;
                     end else begin
                        c_d = c_q + 1'b1;
                     end
                  end else begin
                     v_d = v_q + 1'b1;
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         state_q <= ST_IDLE;
         coef_q  <= '0;
         asg_q   <= '0;
         v_q     <= '0;
         c_q     <= '0;
         fin_q   <= 1'b0;
         flags_q <= '0;
         any_q   <= 1'b0;
         first_q <= '0;
      end else begin
         state_q <= state_d;
         coef_q  <= coef_d;
         asg_q   <= asg_d;
         v_q     <= v_d;
         c_q     <= c_d;
         fin_q   <= fin_d;
         flags_q <= flags_d;
         any_q   <= any_d;
         first_q <= first_d;
      end
   end

   assign out_busy           = (state_q == ST_RUN);
   assign out_done           = (state_q == ST_DONE);
   assign out_clause_flags   = flags_q;
   assign out_all_satisfied  = &flags_q;
   assign out_any_violated   = any_q;
   assign out_first_violated = first_q;

endmodule

// File: tb/tb_clause_checker_seq.sv
// Scoreboard bench: a full-evaluation and an early-exit instance share stimulus;
// expected results come from plain integer evaluation of each clause.
module tb_clause_checker_seq;

   localparam int W = 8;
   localparam int V = 2;
   localparam int C = 2;

   typedef struct {
      logic [1:0] flags;
      logic       all_s;
      logic       any_v;
      logic [0:0] first_v;
      int         lat;
      int         hold;
      int         t_en;
      int         t_wall;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, en, start;
   logic [47:0] coef;
   logic [15:0] asg;

   logic        busy0, done0, all0, any0, busy1, done1, all1, any1;
   logic [1:0]  flags0, flags1;
   logic [0:0]  first0, first1;

   int checks = 0;
   int failures = 0;
   int en_cnt = 0;
   int cyc_cnt = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (en) en_cnt <= en_cnt + 1;
   end

   clause_checker_seq #(.WIDTH(W), .NUM_VARS(V), .NUM_CLAUSES(C), .EARLY_EXIT(0)) dut_full (
      .in_clk(clk), .in_reset(rst_n), .in_enable(en), .in_start(start),
      .in_coefficients(coef), .in_current_assignment(asg),
      .out_busy(busy0), .out_done(done0), .out_clause_flags(flags0),
      .out_all_satisfied(all0), .out_any_violated(any0), .out_first_violated(first0)
   );

   clause_checker_seq #(.WIDTH(W), .NUM_VARS(V), .NUM_CLAUSES(C), .EARLY_EXIT(1)) dut_early (
      .in_clk(clk), .in_reset(rst_n), .in_enable(en), .in_start(start),
      .in_coefficients(coef), .in_current_assignment(asg),
      .out_busy(busy1), .out_done(done1), .out_clause_flags(flags1),
      .out_all_satisfied(all1), .out_any_violated(any1), .out_first_violated(first1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic exp_t model(input logic [47:0] cf, input logic [15:0] y, input bit early);
      exp_t e;
      int   sum, a, yy, b;
      bit   stop;
      e.flags = '0; e.all_s = 1'b0; e.any_v = 1'b0; e.first_v = '0;
      e.lat = C * V + 1; e.hold = 0; e.t_en = 0; e.t_wall = 0;
      stop = 1'b0;
      for (int c = 0; c < C; c++) begin
         if (!stop) begin
            sum = 0;
            for (int v = 0; v < V; v++) begin
               a   = int'($signed(cf[(c*(V+1)+v)*W +: W]));
               yy  = int'($signed(y[v*W +: W]));
               sum = sum + a * yy;
            end
            b = int'($signed(cf[(c*(V+1)+V)*W +: W]));
            e.flags[c] = (sum <= b);
            if (sum > b) begin
               if (!e.any_v) e.first_v = 1'(c);
               e.any_v = 1'b1;
               if (early) begin
                  stop  = 1'b1;
                  e.lat = (c + 1) * V + 1;
               end
            end
         end
      end
      e.all_s = &e.flags;
      return e;
   endfunction

   task automatic check_done(input int which, input logic [1:0] fl, input logic al,
                             input logic an, input logic [0:0] fv);
      exp_t e;
      if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
         checks++;
         failures++;
         $display("FAIL dut%0d unexpected_done actual=1 required=0", which);
      end else begin
         if (which == 0) e = q0.pop_front();
         else            e = q1.pop_front();
         chk($sformatf("dut%0d flags", which), 64'(fl), 64'(e.flags));
         chk($sformatf("dut%0d all_satisfied", which), 64'(al), 64'(e.all_s));
         chk($sformatf("dut%0d any_violated", which), 64'(an), 64'(e.any_v));
         chk($sformatf("dut%0d first_violated", which), 64'(fv), 64'(e.first_v));
         chk($sformatf("dut%0d latency_enabled", which), 64'(en_cnt - e.t_en), 64'(e.lat));
         chk($sformatf("dut%0d latency_wall", which), 64'(cyc_cnt - e.t_wall), 64'(e.lat + e.hold));
      end
   endtask

   // Monitor: one scoreboard pop per done pulse (a pulse held by in_enable=0 counts once).
   initial begin
      logic p0, p1;
      p0 = 1'b0;
      p1 = 1'b0;
      forever begin
         @(negedge clk);
         if (done0 && !p0) check_done(0, flags0, all0, any0, first0);
         if (done1 && !p1) check_done(1, flags1, all1, any1, first1);
         p0 = done0;
         p1 = done1;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((busy0 || done0 || busy1 || done1 || q0.size() != 0 || q1.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL wait_idle timeout actual=%0d required<200", n);
         q0.delete();
         q1.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " dut0 outputs"}, 64'({busy0, done0, flags0, all0, any0, first0}), 64'd0);
      chk({tag, " dut1 outputs"}, 64'({busy1, done1, flags1, all1, any1, first1}), 64'd0);
   endtask

   task automatic run(input logic [47:0] cf, input logic [15:0] y, input int hold, input bit extra);
      exp_t e0, e1;
      @(negedge clk);
      coef  = cf;
      asg   = y;
      en    = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      e0 = model(cf, y, 1'b0);
      e1 = model(cf, y, 1'b1);
      e0.hold = hold;   e1.hold = hold;
      e0.t_en = en_cnt; e1.t_en = en_cnt;
      e0.t_wall = cyc_cnt; e1.t_wall = cyc_cnt;
      q0.push_back(e0);
      q1.push_back(e1);
      chk("busy after start dut0", 64'(busy0), 64'd1);
      chk("busy after start dut1", 64'(busy1), 64'd1);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      if (hold > 0) begin
         en = 1'b0;
         repeat (hold) @(negedge clk);
         en = 1'b1;
      end
      if (extra) begin
         coef  = {16'($urandom), $urandom};
         asg   = 16'($urandom);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      start = 1'b0;
      coef  = '0;
      asg   = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      run(48'h010101_020101, 16'h0101, 0, 1'b0); wait_idle();
      run(48'h010101_020101, 16'hffff, 0, 1'b0); wait_idle();
      run(48'h000000_7f8080, 16'h8080, 0, 1'b0); wait_idle();
      run(48'h000000_807f7f, 16'h8080, 0, 1'b0); wait_idle();
      run(48'h010101_020101, 16'h0101, 3, 1'b1); wait_idle();
      run(48'h010101_010101, 16'h0101, 0, 1'b0); wait_idle();

      run(48'h010101_020101, 16'h0101, 0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      q0.delete();
      q1.delete();
      #1 check_zero("mid-run reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      run(48'h010101_020101, 16'h0101, 0, 1'b0); wait_idle();

      for (int i = 0; i < 150; i++) begin
         logic [47:0] cf;
         logic [15:0] y;
         int          h;
         cf = {16'($urandom), $urandom};
         y  = 16'($urandom);
         h  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         run(cf, y, h, ($urandom_range(0, 2) == 0));
         wait_idle();
      end

      chk("scoreboard drained dut0", 64'(q0.size()), 64'd0);
      chk("scoreboard drained dut1", 64'(q1.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
